// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, UART
// defaults shared with uart_2, and the grant index width helper.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   localparam int UART_CLK_IN = 12000000;
   localparam int UART_BAUD   = 115200;

   // Index width for n requesters, never narrower than one bit.
   function automatic int id_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the uart_2 transmit handshake.
// master = client/UART side, slave = arbiter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           uart_data;
   logic                 uart_start;
   logic                 uart_ready;
   logic                 uart_sending;

   modport master (
      output req_valid, req_data, req_last, uart_ready, uart_sending,
      input  req_ready, uart_data, uart_start
   );

   modport slave (
      input  req_valid, req_data, req_last, uart_ready, uart_sending,
      output req_ready, uart_data, uart_start
   );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req_mask at or after ptr, wrapping
// modulo N. Purely combinational.
module rr_pick
   import uart_pkg::*;
#(
   parameter  int N    = 4,
   localparam int ID_W = id_width(N)
) (
   input  logic [N-1:0]    req_mask,
   input  logic [ID_W-1:0] ptr,
   output logic            any,
   output logic [ID_W-1:0] win
);

   logic [ID_W-1:0] w_idx;

   // Scan from the farthest offset down so the nearest candidate is written last.
   always_comb begin
      any   = 1'b0;
      win   = '0;
      w_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_idx = ID_W'((int'(ptr) + k) % N);
         any   = any | req_mask[w_idx];
         win   = req_mask[w_idx] ? w_idx : win;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_2 transmitter among NUM_REQ byte requesters with
// round-robin arbitration and packet locking with an idle timeout.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int NUM_REQ      = 4,
   parameter  int LOCK_TIMEOUT = 65535,
   localparam int ID_W         = id_width(NUM_REQ)
) (
   input  logic              clk,
   input  logic              reset,
   uart_tx_arbiter_if.slave  bus,
   output logic [ID_W-1:0]   grant_id,
   output logic              locked,
   output logic              busy
);

   localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;

   state_t            r_state;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [ID_W-1:0]   r_grant;
   logic              r_locked;
   logic [7:0]        r_data;
   logic [CNT_W-1:0]  r_lock_cnt;

   state_t            w_next_state;
   logic [NUM_REQ-1:0] w_mask;
   logic              w_any;
   logic [ID_W-1:0]   w_win;
   logic              w_accept;
   logic              w_start;
   logic              w_lock_silent;
   logic              w_timeout;
   logic [7:0]        w_bytes [NUM_REQ];

   // Unpack the flat data bus into one byte per requester.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_bytes[i] = bus.req_data[8*i +: 8];
      end
   end

   // While locked only the lock owner may compete.
   assign w_mask = r_locked ? (bus.req_valid & (NUM_REQ'(1) << r_grant)) : bus.req_valid;

   rr_pick #(.N(NUM_REQ)) u_pick (
      .req_mask (w_mask),
      .ptr      (r_rr_ptr),
      .any      (w_any),
      .win      (w_win)
   );

   assign w_lock_silent = (r_state == IDLE) && r_locked && !bus.req_valid[r_grant];
   assign w_timeout     = (LOCK_TIMEOUT != 0) && w_lock_silent &&
                          (r_lock_cnt == CNT_W'(LOCK_TIMEOUT - 1));

   // Next-state and handshake decode.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_start      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_accept     = 1'b1;
               w_next_state = START;
            end else begin
               w_next_state = IDLE;
            end
         end
         START: begin
            // uart_2 only leaves idle on a baud tick, so hold start until it reports sending.
            w_start = 1'b1;
            if (bus.uart_sending) begin
               w_next_state = WAIT_DONE;
            end else begin
               w_next_state = START;
            end
         end
         WAIT_DONE: begin
            if (bus.uart_ready && !bus.uart_sending) begin
               w_next_state = IDLE;
            end else begin
               w_next_state = WAIT_DONE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // State, capture, round-robin pointer and lock bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_rr_ptr   <= '0;
         r_grant    <= '0;
         r_locked   <= 1'b0;
         r_data     <= 8'h00;
         r_lock_cnt <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_data     <= w_bytes[w_win];
            r_grant    <= w_win;
            r_locked   <= ~bus.req_last[w_win];
            r_rr_ptr   <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
            r_lock_cnt <= '0;
         end else if (w_timeout) begin
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
         end else if (w_lock_silent) begin
            r_lock_cnt <= r_lock_cnt + CNT_W'(1);
         end else if (!r_locked) begin
            r_lock_cnt <= '0;
         end else begin
            r_lock_cnt <= r_lock_cnt;
         end
      end
   end

   assign bus.req_ready  = w_accept ? (NUM_REQ'(1) << w_win) : '0;
   assign bus.uart_data  = r_data;
   assign bus.uart_start = w_start;
   assign grant_id       = r_grant;
   assign locked         = r_locked;
   assign busy           = (r_state != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_2` transmitter among `NUM_REQ` byte-stream requesters using round-robin arbitration, with optional packet locking so multi-byte messages are never interleaved. It sits between client logic (status reporters, debug dumpers, command responders) and the `uart_2` instance. It drives `tx_input`/`tx_start` and sequences each byte through the transmitter's `tx_ready`/`tx_sending` handshake.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `LOCK_TIMEOUT`, 65535: idle cycles after which a held packet lock is forcibly released; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock; the block uses this single clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester i has a byte.
- `req_data`  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
- `req_last`  in  NUM_REQ  byte is the final byte of its packet.
- `req_ready`  out  NUM_REQ  one-hot accept pulse; transfer occurs when valid and ready are both high.
- `uart_data`  out  8  connects to `tx_input`.
- `uart_start`  out  1  connects to `tx_start`.
- `uart_ready`  in  1  from `tx_ready`.
- `uart_sending`  in  1  from `tx_sending`.
- `grant_id`  out  ID_W  index of the current or last winner; ID_W = max(1, clog2(NUM_REQ)).
- `locked`  out  1  a packet lock is held.
- `busy`  out  1  state is not IDLE.

## Operation
- States are IDLE, START, WAIT_DONE.
- IDLE, unlocked:
  - Search `req_valid` starting at `rr_ptr` and wrapping modulo NUM_REQ.
  - The first set bit wins.
  - `req_ready[win]` = 1 combinationally in this cycle; all other ready bits are 0.
  - On the edge, capture `req_data[win]` into `uart_data` and set `grant_id` = win.
  - Set `locked` = ~`req_last[win]`, set `rr_ptr` = (win+1) mod NUM_REQ, and go to START.
- IDLE, locked: only `req_valid[grant_id]` is considered. Other requesters wait; `rr_ptr` is unchanged.
- No valid requester: stay in IDLE and drive all `req_ready` low.
- START:
  - Drive `uart_start` = 1.
  - Hold it until `uart_sending` = 1 is sampled. The transmitter only leaves idle on its baud tick, so a single-cycle start is insufficient.
  - Then go to WAIT_DONE.
- WAIT_DONE: drive `uart_start` = 0. Go to IDLE when `uart_ready` = 1 and `uart_sending` = 0 are sampled together.
- `uart_data` is stable from capture until the next IDLE capture.
- Lock timeout:
  - `lock_cnt` counts IDLE cycles while locked and `req_valid[grant_id]` = 0.
  - When `lock_cnt` reaches LOCK_TIMEOUT, clear `locked`. Arbitration resumes in the next cycle.
  - `lock_cnt` clears on any accept and whenever the block is unlocked.
- When NUM_REQ is not a power of two, `rr_ptr` wraps explicitly: NUM_REQ-1 goes to 0.

## Timing
- Reset values: state = IDLE, `req_ready` = 0, `uart_data` = 8'h00, `uart_start` = 0, `grant_id` = 0, `locked` = 0, `busy` = 0, `rr_ptr` = 0, `lock_cnt` = 0.
- `req_valid` rises in IDLE at cycle N. The accept happens at N, and `uart_start` = 1 from N+1.
- End-to-end byte time is 1 cycle (IDLE) + wait for baud tick + full UART frame + 1 cycle.
- The minimum gap between successive accepts is the UART frame time plus 2 cycles.
- Requesters must hold `req_valid` and `req_data` until they see `req_ready`. Deasserting valid before the accept is allowed; the byte is simply not taken.
- Reset asserted mid-byte returns all state to reset values on the next edge and drops `uart_start`. The in-flight UART frame is the UART's own concern; it is reset by the same `reset`.
- If `uart_sending` is already 1 on entry to START, go to WAIT_DONE after one cycle. WAIT_DONE does not exit while `uart_sending` is still 1.

## Structure
- Package `uart_pkg` holds:
  - state encoding constants (IDLE = 2'd0, START = 2'd1, WAIT_DONE = 2'd2);
  - `UART_CLK_IN` = 12000000 and `UART_BAUD` = 115200 defaults shared with `uart_2`.
- Sub-module `rr_pick`, purely combinational: inputs `req_mask` and `ptr`; outputs `any` and `win` index. It is instantiated once.
- The top level contains the FSM, capture registers, lock logic and `lock_cnt`.

## Test plan
- Single byte: after reset, requester 2 presents 8'hA5 with last = 1.
  - `req_ready[2]` pulses once.
  - `uart_data` = 8'hA5.
  - `uart_start` is held until `uart_sending` rises.
  - The line shows frame 0,10100101 LSB-first,1, then `busy` returns to 0.
- Round-robin: requesters 0 to 3 all valid with last = 1. Accept order is 0,1,2,3,0. `rr_ptr` wraps 3 to 0.
- Packet lock: requester 1 sends 3 bytes (last = 0,0,1) while requester 0 is continuously valid.
  - Bytes 1,1,1 are sent before any byte from 0.
  - `locked` is high between the bytes.
- Lock timeout: LOCK_TIMEOUT = 8, requester 3 sends a byte with last = 0, then goes silent while requester 0 is valid.
  - `locked` clears after 8 IDLE cycles.
  - Requester 0 is accepted on the next cycle.
- Reset mid-transfer: assert `reset` for 1 cycle during WAIT_DONE. All outputs return to reset values, and a fresh request is served normally.
- Non-power-of-2: NUM_REQ = 3, all valid. Order is 0,1,2,0. `grant_id` never equals 3.
